// File: rtl/serialmul_ctrl.sv
// Sequencer and datapath for a W-cell bit-serial multiply-add array: latches a/b,
// streams b LSB-first with sync, and deserialises the 2W-bit product. Option: SERIALMUL_ABORT_EN.
module serialmul_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
`ifdef SERIALMUL_ABORT_EN
  input  logic           abort,
`endif
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int unsigned CW = $clog2(2 * W + 1);
  localparam logic [CW-1:0] LastCnt = CW'(2 * W);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    a_q, b_sr_q;
  logic [2*W-2:0]  prod_sr_q;
  logic [2*W-1:0]  p_q;
  logic [W-1:0]    sum_q, carry_q, sum_d, carry_d, sum_in;
  logic            accept, slot, sync, b_bit, abort_run;

`ifdef SERIALMUL_ABORT_EN
  assign abort_run = abort;
`else
  assign abort_run = 1'b0;
`endif

  assign accept = start && (state_q != StRun);
  assign slot   = (state_q == StRun) && (cnt_q != LastCnt);
  assign sync   = slot && (cnt_q == '0);
  assign b_bit  = b_sr_q[0];

  // sync drops both feedback terms so stale cell state from an aborted run is discarded
  assign sum_in = {1'b0, sum_q[W-1:1]} & {W{~sync}};

  for (genvar i = 0; i < W; i++) begin : g_cell
    logic [1:0] tot;
    assign tot = 2'(a_q[i] & b_bit) + 2'(sum_in[i]) + 2'(carry_q[i] & ~sync);
    assign sum_d[i]   = tot[0];
    assign carry_d[i] = tot[1];
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StRun;
      end
      StRun: begin
        busy = 1'b1;
        if (abort_run)              state_d = StIdle;
        else if (cnt_q == LastCnt)  state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = accept ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_sr_q    <= '0;
      prod_sr_q <= '0;
      p_q       <= '0;
      sum_q     <= '0;
      carry_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= a;
        b_sr_q <= b;
        cnt_q  <= '0;
      end else if (state_q == StRun) begin
        cnt_q <= cnt_q + 1'b1;
        if (slot) b_sr_q <= b_sr_q >> 1;
      end
      if (slot) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
      // Cell output is registered, so product bit k appears while the counter reads k+1
      if (state_q == StRun && cnt_q != '0) prod_sr_q <= {sum_q[0], prod_sr_q[2*W-2:1]};
      if (state_q == StRun && cnt_q == LastCnt && !abort_run) p_q <= {sum_q[0], prod_sr_q};
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_serialmul_ctrl.sv
// Self-checking bench for serialmul_ctrl (W=8): cycle-level behavioural model plus
// directed vectors with literal expectations. Abort tests need SERIALMUL_ABORT_EN.
module tb_serialmul_ctrl;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] p;
  logic           abort_eff;
`ifdef SERIALMUL_ABORT_EN
  logic           abort;
  assign abort_eff = abort;
`else
  assign abort_eff = 1'b0;
`endif

  serialmul_ctrl #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef SERIALMUL_ABORT_EN
    .abort (abort),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a run lasts 2W+1 cycles; done follows; p takes a*b when done appears
  int             run_left = 0;
  bit             m_done = 1'b0;
  logic [2*W-1:0] m_p = '0;
  logic [2*W-1:0] m_pend = '0;
  bit             model_en = 1'b0;

  always @(posedge clk) begin
    int old;
    if (reset) begin
      run_left = 0;
      m_done   = 1'b0;
      m_p      = '0;
    end else begin
      old    = run_left;
      m_done = 1'b0;
      if (old > 0) begin
        run_left = old - 1;
        if (abort_eff) run_left = 0;
        else if (old == 1) begin
          m_done = 1'b1;
          m_p    = m_pend;
        end
      end
      if (old == 0 && start) begin
        m_pend   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        run_left = 2 * W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      chk("model busy", busy, (run_left > 0));
      chk("model done", done, m_done);
      chk("model p", p, m_p);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Current negedge is k=1; returns at the negedge where done is high (or after the bound)
  task automatic run_wait(output int k, output int nbusy, output bit seen);
    k = 1; nbusy = 0; seen = 1'b0;
    while (!seen && k <= 40) begin
      if (busy) nbusy++;
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
  endtask

  task automatic do_mul(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [2*W-1:0] exp, input string nm);
    int k, nbusy;
    bit seen;
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_wait(k, nbusy, seen);
    chk({nm, " done seen"}, done, 1);
    chk({nm, " latency"}, k, 18);
    chk({nm, " busy cycles"}, nbusy, 17);
    chk({nm, " busy in done"}, busy, 0);
    chk({nm, " p"}, p, exp);
    @(negedge clk);
  endtask

  initial begin
    int k, nbusy;
    bit seen;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
`ifdef SERIALMUL_ABORT_EN
    abort = 1'b0;
`endif
    cyc(3);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset p", p, 0);
    reset = 1'b0;
    model_en = 1'b1;
    cyc(2);

    do_mul(8'h0D, 8'h0B, 16'h008F, "0d*0b");
    do_mul(8'hFF, 8'hFF, 16'hFE01, "ff*ff");
    do_mul(8'h00, 8'hA5, 16'h0000, "00*a5");
    do_mul(8'h01, 8'h80, 16'h0080, "01*80");

    // Back-to-back: start held, new operands presented in the done cycle
    a = 8'd3; b = 8'd5; start = 1'b1;
    @(negedge clk);
    run_wait(k, nbusy, seen);
    chk("b2b first latency", k, 18);
    chk("b2b first p", p, 16'h000F);
    a = 8'd7; b = 8'd9;
    @(negedge clk);
    start = 1'b0;
    run_wait(k, nbusy, seen);
    chk("b2b spacing", k, 18);
    chk("b2b second p", p, 16'h003F);
    @(negedge clk);

    // Start and operand changes mid-run are ignored
    a = 8'h0D; b = 8'h0B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc(4);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    cyc(2);
    start = 1'b0; a = 8'h55; b = 8'h66;
    run_wait(k, nbusy, seen);
    chk("midrun done seen", done, 1);
    chk("midrun p", p, 16'h008F);
    @(negedge clk);

    // Reset at counter=5 aborts silently and clears p
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc(5);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset p", p, 0);
    reset = 1'b0;
    cyc(2);
    do_mul(8'h12, 8'h34, 16'h03A8, "12*34");

`ifdef SERIALMUL_ABORT_EN
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc(3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort p", p, 16'h03A8);
    cyc(20);
    do_mul(8'hC8, 8'h0A, 16'h07D0, "c8*0a");
`endif

    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
